// File: rtl/player_ctrl_if.sv
// ============================================================================
// Module      : player_ctrl_if
// Description : Game-state, key/collision inputs and sprite outputs of the
//               player motion/animation controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface player_ctrl_if;
    logic [3:0] state;
    logic       frame_tick;
    logic       key_up;
    logic       key_down;
    logic       key_left;
    logic       key_right;
    logic       blk_up;
    logic       blk_down;
    logic       blk_left;
    logic       blk_right;
    logic [8:0] player_x;
    logic [8:0] player_y;
    logic [3:0] player_state;
    logic       moving;

    // Master drives the game inputs and observes the sprite outputs.
    modport master (
        output state, frame_tick,
        output key_up, key_down, key_left, key_right,
        output blk_up, blk_down, blk_left, blk_right,
        input  player_x, player_y, player_state, moving
    );

    modport slave (
        input  state, frame_tick,
        input  key_up, key_down, key_left, key_right,
        input  blk_up, blk_down, blk_left, blk_right,
        output player_x, player_y, player_state, moving
    );
endinterface

`default_nettype wire

// File: rtl/player_ctrl.sv
// ============================================================================
// Module      : player_ctrl
// Description : Player motion/animation controller for STAGE1-3. Produces the
//               registered sprite position and frame index (dir*3 + phase).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_ctrl #(
    parameter logic [8:0] X_MAX    = 9'd310,
    parameter logic [8:0] Y_MAX    = 9'd230,
    parameter logic [8:0] STEP     = 9'd2,
    parameter logic [3:0] MOVE_DIV = 4'd2,
    parameter logic [3:0] ANIM_DIV = 4'd8,
    parameter logic [8:0] SPAWN1_X = 9'd10,
    parameter logic [8:0] SPAWN1_Y = 9'd110,
    parameter logic [8:0] SPAWN2_X = 9'd10,
    parameter logic [8:0] SPAWN2_Y = 9'd10,
    parameter logic [8:0] SPAWN3_X = 9'd150,
    parameter logic [8:0] SPAWN3_Y = 9'd220
) (
    input  wire logic     clk,
    input  wire logic     rst,
    player_ctrl_if.slave  bus
);

    localparam logic [3:0] GS_STAGE1 = 4'd2;
    localparam logic [3:0] GS_STAGE2 = 4'd4;
    localparam logic [3:0] GS_STAGE3 = 4'd6;

    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] PH_STAND  = 2'd0;
    localparam logic [1:0] PH_WALK1  = 2'd1;
    localparam logic [1:0] PH_WALK2  = 2'd2;

    localparam logic [3:0] MOVE_LAST = MOVE_DIV - 4'd1;
    localparam logic [3:0] ANIM_LAST = ANIM_DIV - 4'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SPAWN = 2'd1,
        S_PLAY  = 2'd2
    } fsm_t;

    fsm_t       fsm_q, fsm_d;
    logic [3:0] prev_state_q;
    logic [8:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] phase_q, phase_d;
    logic [3:0] mv_cnt_q, mv_cnt_d;
    logic [3:0] anim_cnt_q, anim_cnt_d;
    logic       moving_q, moving_d;
    logic [3:0] player_state_q, player_state_d;

    // ------------------------------------------------------------------------
    // Stage decode and spawn point selection
    // ------------------------------------------------------------------------
    logic       is_stage;
    logic       state_changed;
    logic [8:0] spawn_x;
    logic [8:0] spawn_y;

    always_comb begin
        is_stage      = (bus.state == GS_STAGE1) || (bus.state == GS_STAGE2) ||
                        (bus.state == GS_STAGE3);
        state_changed = (bus.state != prev_state_q);
        spawn_x       = SPAWN1_X;
        spawn_y       = SPAWN1_Y;
        case (bus.state)
            GS_STAGE2: begin
                spawn_x = SPAWN2_X;
                spawn_y = SPAWN2_Y;
            end
            GS_STAGE3: begin
                spawn_x = SPAWN3_X;
                spawn_y = SPAWN3_Y;
            end
            default: begin
                spawn_x = SPAWN1_X;
                spawn_y = SPAWN1_Y;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Key priority (up > down > left > right) and blocking of the chosen way
    // ------------------------------------------------------------------------
    logic       key_any;
    logic [1:0] key_dir;
    logic       key_blocked;

    always_comb begin
        key_any = bus.key_up | bus.key_down | bus.key_left | bus.key_right;
        if (bus.key_up) begin
            key_dir = DIR_UP;
        end else if (bus.key_down) begin
            key_dir = DIR_DOWN;
        end else if (bus.key_left) begin
            key_dir = DIR_LEFT;
        end else begin
            key_dir = DIR_RIGHT;
        end
        case (key_dir)
            DIR_UP:   key_blocked = bus.blk_up;
            DIR_DOWN: key_blocked = bus.blk_down;
            DIR_LEFT: key_blocked = bus.blk_left;
            default:  key_blocked = bus.blk_right;
        endcase
    end

    // ------------------------------------------------------------------------
    // Saturating step targets; sums are one bit wider so they cannot wrap
    // ------------------------------------------------------------------------
    logic [9:0] x_sum;
    logic [9:0] y_sum;
    logic [8:0] x_inc;
    logic [8:0] x_dec;
    logic [8:0] y_inc;
    logic [8:0] y_dec;

    always_comb begin
        x_sum = {1'b0, x_q} + {1'b0, STEP};
        y_sum = {1'b0, y_q} + {1'b0, STEP};
        x_inc = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[8:0];
        y_inc = (y_sum > {1'b0, Y_MAX}) ? Y_MAX : y_sum[8:0];
        x_dec = (x_q < STEP) ? 9'd0 : (x_q - STEP);
        y_dec = (y_q < STEP) ? 9'd0 : (y_q - STEP);
    end

    // ------------------------------------------------------------------------
    // Next-state and motion logic
    // ------------------------------------------------------------------------
    always_comb begin
        fsm_d      = fsm_q;
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        phase_d    = phase_q;
        mv_cnt_d   = mv_cnt_q;
        anim_cnt_d = anim_cnt_q;
        moving_d   = moving_q;

        case (fsm_q)
            S_IDLE: begin
                moving_d = 1'b0;
                if (is_stage && state_changed) begin
                    fsm_d = S_SPAWN;
                end
            end

            S_SPAWN: begin
                fsm_d      = S_PLAY;
                x_d        = spawn_x;
                y_d        = spawn_y;
                dir_d      = DIR_DOWN;
                phase_d    = PH_STAND;
                mv_cnt_d   = 4'd0;
                anim_cnt_d = 4'd0;
                moving_d   = 1'b0;
            end

            S_PLAY: begin
                // Leaving the stages freezes the sprite so it stays visible
                // on the SUCCESS/FAIL screens.
                if (!is_stage) begin
                    fsm_d    = S_IDLE;
                    moving_d = 1'b0;
                end else if (state_changed) begin
                    fsm_d = S_SPAWN;
                end else if (bus.frame_tick) begin
                    if (!key_any || key_blocked) begin
                        if (key_any) begin
                            dir_d = key_dir;
                        end
                        phase_d    = PH_STAND;
                        mv_cnt_d   = 4'd0;
                        anim_cnt_d = 4'd0;
                        moving_d   = 1'b0;
                    end else begin
                        dir_d    = key_dir;
                        moving_d = 1'b1;

                        if (mv_cnt_q == MOVE_LAST) begin
                            mv_cnt_d = 4'd0;
                            case (key_dir)
                                DIR_UP:   y_d = y_dec;
                                DIR_DOWN: y_d = y_inc;
                                DIR_LEFT: x_d = x_dec;
                                default:  x_d = x_inc;
                            endcase
                        end else begin
                            mv_cnt_d = mv_cnt_q + 4'd1;
                        end

                        // The first moving tick starts a full ANIM_DIV-long
                        // walk-1 period; later ticks count toward the toggle.
                        if (phase_q == PH_STAND) begin
                            phase_d    = PH_WALK1;
                            anim_cnt_d = 4'd0;
                        end else if (anim_cnt_q == ANIM_LAST) begin
                            phase_d    = (phase_q == PH_WALK1) ? PH_WALK2 : PH_WALK1;
                            anim_cnt_d = 4'd0;
                        end else begin
                            anim_cnt_d = anim_cnt_q + 4'd1;
                        end
                    end
                end
            end

            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        player_state_d = ({2'b00, dir_d} * 4'd3) + {2'b00, phase_d};
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q          <= S_IDLE;
            prev_state_q   <= 4'd0;
            x_q            <= 9'd0;
            y_q            <= 9'd0;
            dir_q          <= DIR_DOWN;
            phase_q        <= PH_STAND;
            mv_cnt_q       <= 4'd0;
            anim_cnt_q     <= 4'd0;
            moving_q       <= 1'b0;
            player_state_q <= 4'd0;
        end else begin
            fsm_q          <= fsm_d;
            prev_state_q   <= bus.state;
            x_q            <= x_d;
            y_q            <= y_d;
            dir_q          <= dir_d;
            phase_q        <= phase_d;
            mv_cnt_q       <= mv_cnt_d;
            anim_cnt_q     <= anim_cnt_d;
            moving_q       <= moving_d;
            player_state_q <= player_state_d;
        end
    end

    assign bus.player_x     = x_q;
    assign bus.player_y     = y_q;
    assign bus.player_state = player_state_q;
    assign bus.moving       = moving_q;

endmodule

`default_nettype wire

// File: tb/tb_player_ctrl.sv
// ============================================================================
// Module      : tb_player_ctrl
// Description : Directed scoreboard bench for player_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_player_ctrl;

    logic clk;
    logic rst;

    player_ctrl_if bus ();

    player_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic [3:0] ps;
        logic       mv;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks;
    int    errors;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic push(input string tag, input int x, input int y, input int ps, input int mv);
        exp_t e;
        e.x  = x[8:0];
        e.y  = y[8:0];
        e.ps = ps[3:0];
        e.mv = mv[0];
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check();
        exp_t  e;
        exp_t  o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o.x  = bus.player_x;
        o.y  = bus.player_y;
        o.ps = bus.player_state;
        o.mv = bus.moving;
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed x=%0d y=%0d ps=%0d mv=%0d expected x=%0d y=%0d ps=%0d mv=%0d",
                   t, o.x, o.y, o.ps, o.mv, e.x, e.y, e.ps, e.mv);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.state      = 4'd0;
        bus.frame_tick = 1'b0;
        bus.key_up     = 1'b0;
        bus.key_down   = 1'b0;
        bus.key_left   = 1'b0;
        bus.key_right  = 1'b0;
        bus.blk_up     = 1'b0;
        bus.blk_down   = 1'b0;
        bus.blk_left   = 1'b0;
        bus.blk_right  = 1'b0;

        // Reset and idle on the title screen
        push("reset", 0, 0, 0, 0);
        clk1(); clk1();
        check();
        rst = 1'b0;
        push("title_idle", 0, 0, 0, 0);
        ticks(10);
        check();

        // Spawn sequencing across stages
        bus.state = 4'd2;
        push("spawn_wait", 0, 0, 0, 0);
        clk1();
        check();
        push("spawn1", 10, 110, 0, 0);
        clk1();
        check();
        bus.state = 4'd4;
        push("spawn2", 10, 10, 0, 0);
        clk1(); clk1();
        check();
        bus.state = 4'd2;
        push("spawn1_again", 10, 110, 0, 0);
        clk1(); clk1();
        check();

        // Walking right: step every 2nd tick, phase toggle after 8 ticks
        bus.key_right = 1'b1;
        push("right_t1", 10, 110, 10, 1);
        tick();
        check();
        push("right_t2", 12, 110, 10, 1);
        tick();
        check();
        push("hold_no_tick", 12, 110, 10, 1);
        clk1();
        check();
        push("right_t6", 16, 110, 10, 1);
        ticks(4);
        check();
        push("right_t8", 18, 110, 10, 1);
        ticks(2);
        check();
        push("right_t9", 18, 110, 11, 1);
        tick();
        check();
        bus.key_right = 1'b0;
        push("release", 18, 110, 9, 0);
        tick();
        check();

        // Down clamp at Y_MAX in stage 3
        bus.state = 4'd6;
        push("spawn3", 150, 220, 0, 0);
        clk1(); clk1();
        check();
        bus.key_down = 1'b1;
        push("down_t2", 150, 222, 1, 1);
        ticks(2);
        check();
        push("down_t10", 150, 230, 2, 1);
        ticks(8);
        check();
        push("down_clamp", 150, 230, 2, 1);
        ticks(2);
        check();
        bus.key_down = 1'b0;
        push("down_release", 150, 230, 0, 0);
        tick();
        check();

        // Right clamp at X_MAX
        bus.key_right = 1'b1;
        push("right_max", 310, 230, 11, 1);
        ticks(160);
        check();
        push("right_clamp", 310, 230, 10, 1);
        ticks(2);
        check();
        bus.key_right = 1'b0;

        // Up clamp at 0 in stage 2
        bus.state = 4'd4;
        push("spawn2_b", 10, 10, 0, 0);
        clk1(); clk1();
        check();
        bus.key_up = 1'b1;
        push("up_t10", 10, 0, 5, 1);
        ticks(10);
        check();
        push("up_clamp", 10, 0, 5, 1);
        ticks(2);
        check();
        bus.key_up = 1'b0;

        // Blocked direction and key priority
        bus.state = 4'd2;
        push("spawn1_b", 10, 110, 0, 0);
        clk1(); clk1();
        check();
        bus.key_up   = 1'b1;
        bus.key_left = 1'b1;
        bus.blk_up   = 1'b1;
        push("blocked", 10, 110, 3, 0);
        tick();
        check();
        push("blocked2", 10, 110, 3, 0);
        tick();
        check();
        bus.key_up = 1'b0;
        push("left_t1", 10, 110, 7, 1);
        tick();
        check();
        push("left_t2", 8, 110, 7, 1);
        tick();
        check();
        bus.key_left = 1'b0;
        bus.blk_up   = 1'b0;
        push("stand_left", 8, 110, 6, 0);
        tick();
        check();

        // Freeze on SUCCESS1
        bus.key_right = 1'b1;
        push("right_b", 10, 110, 10, 1);
        ticks(2);
        check();
        bus.state = 4'd3;
        push("success_freeze", 10, 110, 10, 0);
        clk1();
        check();
        push("success_hold", 10, 110, 10, 0);
        ticks(3);
        check();

        // Reset mid-move, then respawn from prev_state=0
        bus.state = 4'd2;
        push("respawn", 10, 110, 0, 0);
        clk1(); clk1();
        check();
        push("move_before_rst", 12, 110, 10, 1);
        ticks(2);
        check();
        rst            = 1'b1;
        bus.frame_tick = 1'b1;
        push("rst_mid", 0, 0, 0, 0);
        clk1();
        check();
        bus.frame_tick = 1'b0;
        bus.key_right  = 1'b0;
        clk1();
        rst = 1'b0;
        push("post_rst_wait", 0, 0, 0, 0);
        clk1();
        check();
        push("post_rst_spawn", 10, 110, 0, 0);
        clk1();
        check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
